// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control unit: a Moore FSM that steps each instruction
// through fetch, decode, execute, memory and writeback states. Each instruction
// retires with a single PC_ld/instr_done cycle.
// Optional feature: define ILLEGAL_OP_TRAP_EN to send an illegal opcode to a
// sticky TRAP state and add the trap port. Without it, an illegal opcode
// retires as a NOP.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  output logic       IR_ld,
  output logic       PC_ld,
  output logic       Reg_Write,
  output logic       memWrite,
  output logic       memRead,
  output logic       RegDst,
  output logic       ALUsrc,
  output logic       memToReg,
  output logic       PCsrc,
  output logic       Jmp,
  output logic [2:0] ALU_control,
  output logic       instr_done
`ifdef ILLEGAL_OP_TRAP_EN
  ,
  output logic       trap
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXEC   = 4'd3,
    RWB    = 4'd4,
    MADR   = 4'd5,
    MRD    = 4'd6,
    MWB    = 4'd7,
    MWR    = 4'd8,
    IEXE   = 4'd9,
    IWB    = 4'd10,
    BR     = 4'd11,
    JMP    = 4'd12,
`ifdef ILLEGAL_OP_TRAP_EN
    TRAP   = 4'd14
`else
    NOP    = 4'd13
`endif
  } stateT;

  stateT state_q, state_d;
  logic [2:0] aluFromFunct;
  logic [2:0] aluFromOpcode;

  // State register; reset always returns to IDLE, abandoning any instruction in flight
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ALU operation requested by an R-type funct field; unknown functs fall back to ADD
  always_comb begin
    aluFromFunct = ALU_ADD;
    case (funct)
      6'b100000: aluFromFunct = ALU_ADD;
      6'b100010: aluFromFunct = ALU_SUB;
      6'b100100: aluFromFunct = ALU_AND;
      6'b100101: aluFromFunct = ALU_OR;
      6'b101010: aluFromFunct = ALU_SLT;
      default:   aluFromFunct = ALU_ADD;
    endcase
  end

  // Immediate instructions: slti compares, everything else (addi) adds
  always_comb begin
    aluFromOpcode = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
  end

  // Next-state logic: sequence each instruction class and return to FETCH on retire
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = EXEC;
          OP_LW, OP_SW:  state_d = MADR;
          OP_ADDI, OP_SLTI: state_d = IEXE;
          OP_BEQ:        state_d = BR;
          OP_J:          state_d = JMP;
`ifdef ILLEGAL_OP_TRAP_EN
          default:       state_d = TRAP;
`else
          default:       state_d = NOP;
`endif
        endcase
      end
      EXEC:   state_d = RWB;
      RWB:    state_d = FETCH;
      MADR:   state_d = (opcode == OP_LW) ? MRD : MWR;
      MRD:    state_d = MWB;
      MWB:    state_d = FETCH;
      MWR:    state_d = FETCH;
      IEXE:   state_d = IWB;
      IWB:    state_d = FETCH;
      BR:     state_d = FETCH;
      JMP:    state_d = FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
      TRAP:   state_d = TRAP;
`else
      NOP:    state_d = FETCH;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state; only PCsrc also looks at the live Zero flag
  always_comb begin
    IR_ld       = 1'b0;
    PC_ld       = 1'b0;
    Reg_Write   = 1'b0;
    memWrite    = 1'b0;
    memRead     = 1'b0;
    RegDst      = 1'b0;
    ALUsrc      = 1'b0;
    memToReg    = 1'b0;
    PCsrc       = 1'b0;
    Jmp         = 1'b0;
    ALU_control = ALU_ADD;
    instr_done  = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
    trap        = 1'b0;
`endif
    case (state_q)
      IDLE:   ALU_control = 3'b000;
      FETCH:  IR_ld = 1'b1;
      DECODE: begin
      end
      EXEC:   ALU_control = aluFromFunct;
      RWB: begin
        ALU_control = aluFromFunct;
        Reg_Write   = 1'b1;
        RegDst      = 1'b1;
        memToReg    = 1'b1;
        PC_ld       = 1'b1;
        instr_done  = 1'b1;
      end
      MADR:   ALUsrc = 1'b1;
      MRD: begin
        ALUsrc  = 1'b1;
        memRead = 1'b1;
      end
      MWB: begin
        ALUsrc     = 1'b1;
        memRead    = 1'b1;
        Reg_Write  = 1'b1;
        PC_ld      = 1'b1;
        instr_done = 1'b1;
      end
      MWR: begin
        ALUsrc     = 1'b1;
        memWrite   = 1'b1;
        PC_ld      = 1'b1;
        instr_done = 1'b1;
      end
      IEXE: begin
        ALUsrc      = 1'b1;
        ALU_control = aluFromOpcode;
      end
      IWB: begin
        ALUsrc      = 1'b1;
        ALU_control = aluFromOpcode;
        Reg_Write   = 1'b1;
        memToReg    = 1'b1;
        PC_ld       = 1'b1;
        instr_done  = 1'b1;
      end
      BR: begin
        ALU_control = ALU_SUB;
        PCsrc       = Zero;
        PC_ld       = 1'b1;
        instr_done  = 1'b1;
      end
      JMP: begin
        Jmp        = 1'b1;
        PC_ld      = 1'b1;
        instr_done = 1'b1;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      TRAP: begin
        ALU_control = 3'b000;
        trap        = 1'b1;
      end
`else
      NOP: begin
        PC_ld      = 1'b1;
        instr_done = 1'b1;
      end
`endif
      default: ALU_control = 3'b000;
    endcase
  end

endmodule
